// File: rtl/put_dfx_data.sv
// Buffers decapsulated DFX words and writes each one to the VRF through the write arbiter, in order.
// Latency: push to write_req is 2 cycles, done one cycle after grant. No retry: a push while full with no pop is dropped and flagged in overflow.
module put_dfx_data #(
  parameter int DATA_WIDTH     = 1024,
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_DFX_WIDTH = DATA_WIDTH + ADDR_WIDTH,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_dfx_data,
  input  logic [DATA_DFX_WIDTH-1:0]     dfx_data,
  output logic                          dfx_ready,
  output logic                          write_req,
  input  logic                          write_gnt,
  output logic [ADDR_WIDTH-1:0]         vrf_dst_addr,
  output logic [DATA_WIDTH-1:0]         vrf_write_data,
  output logic                          done_put_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_VRF  = 2'd1,
    WRITE_DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      overflow_q, overflow_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [DATA_DFX_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                      full, empty, push, pop;
  logic [DATA_DFX_WIDTH-1:0] head;

  always_comb begin
    full  = (count_q == CNT_W'(FIFO_DEPTH));
    empty = (count_q == '0);
    pop   = (state_q == IDLE) && !empty;
    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    push  = valid_dfx_data && (!full || pop);
    head  = mem_q[rd_ptr_q];

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    state_d    = state_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      addr_d   = head[ADDR_WIDTH-1:0];
      data_d   = head[DATA_DFX_WIDTH-1:ADDR_WIDTH];
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Set has priority over clear so a drop is never lost.
    if (valid_dfx_data && !push) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    case (state_q)
      IDLE:       if (!empty)   state_d = WRITE_VRF;
      WRITE_VRF:  if (write_gnt) state_d = WRITE_DONE;
      WRITE_DONE: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  // Storage needs no reset: entries are only read behind a nonzero count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dfx_data;
    end
  end

  assign dfx_ready      = !full;
  assign fifo_count     = count_q;
  assign overflow       = overflow_q;
  assign write_req      = (state_q == WRITE_VRF);
  assign done_put_data  = (state_q == WRITE_DONE);
  assign vrf_dst_addr   = addr_q;
  assign vrf_write_data = data_q;

endmodule

// File: tb/tb_put_dfx_data.sv
// Bench for put_dfx_data: single-word vector table, directed corner sequences, and a random run checked against an in-order queue.
module tb_put_dfx_data;
  localparam int DW    = 1024;
  localparam int AW    = 10;
  localparam int DFW   = DW + AW;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  typedef logic [DW-1:0] data_t;
  typedef logic [AW-1:0] addr_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           valid_dfx_data = 1'b0;
  logic [DFW-1:0] dfx_data = '0;
  logic           dfx_ready;
  logic           write_req;
  logic           write_gnt = 1'b0;
  addr_t          vrf_dst_addr;
  data_t          vrf_write_data;
  logic           done_put_data;
  logic [CW-1:0]  fifo_count;
  logic           overflow;
  logic           clear_overflow = 1'b0;

  put_dfx_data #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .valid_dfx_data(valid_dfx_data), .dfx_data(dfx_data),
    .dfx_ready(dfx_ready), .write_req(write_req), .write_gnt(write_gnt),
    .vrf_dst_addr(vrf_dst_addr), .vrf_write_data(vrf_write_data),
    .done_put_data(done_put_data), .fifo_count(fifo_count), .overflow(overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Write-port observer: every granted write is logged; done must follow a grant by exactly one cycle.
  addr_t wr_addr_log[$];
  data_t wr_data_log[$];
  int    done_cnt = 0;
  int    bad_done = 0;
  int    unstable = 0;
  logic  prev_fire = 1'b0;
  logic  prev_wait = 1'b0;
  addr_t prev_addr;
  data_t prev_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_fire = 1'b0;
      prev_wait = 1'b0;
    end else begin
      if (done_put_data !== prev_fire) bad_done++;
      if (write_req && prev_wait && (vrf_dst_addr !== prev_addr || vrf_write_data !== prev_data)) unstable++;
      if (write_req && write_gnt) begin
        wr_addr_log.push_back(vrf_dst_addr);
        wr_data_log.push_back(vrf_write_data);
      end
      if (done_put_data) done_cnt++;
      prev_fire = write_req && write_gnt;
      prev_wait = write_req && !write_gnt;
      prev_addr = vrf_dst_addr;
      prev_data = vrf_write_data;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input data_t act, input data_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got low word %08h, expected low word %08h", name, act[31:0], exp[31:0]);
    end
  endtask

  function automatic data_t fill(input logic [7:0] b);
    return {(DW/8){b}};
  endfunction

  function automatic data_t rnd_data();
    data_t d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input addr_t a, input data_t d);
    valid_dfx_data = 1'b1;
    dfx_data = {d, a};
  endtask

  typedef struct {
    addr_t      addr;
    logic [7:0] pat;
    int         gdly;
    bit         gnt_idle;
    int         req_len;
    int         done_at;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int    first_req, req_n, done_n, done_c, wbase, dbase, k;
    bit    bad_hold, seen;
    addr_t first_addr;
    addr_t exp_a[$];
    data_t exp_d[$];

    // addr, pattern, grant delay, grant high while idle, expected request length, expected done cycle
    vecs[0] = '{addr: 10'h012, pat: 8'hA5, gdly: 0, gnt_idle: 1'b1, req_len: 1, done_at: 3};
    vecs[1] = '{addr: 10'h3FF, pat: 8'h5A, gdly: 5, gnt_idle: 1'b0, req_len: 6, done_at: 8};
    vecs[2] = '{addr: 10'h000, pat: 8'hFF, gdly: 2, gnt_idle: 1'b1, req_len: 3, done_at: 5};
    vecs[3] = '{addr: 10'h155, pat: 8'h00, gdly: 1, gnt_idle: 1'b0, req_len: 2, done_at: 4};

    // Reset state
    repeat (3) step();
    chk("rst_write_req", write_req, 0);
    chk("rst_done", done_put_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ready", dfx_ready, 1);
    chk("rst_addr", vrf_dst_addr, 0);
    chk_data("rst_data", vrf_write_data, '0);
    rst_n = 1'b1;
    step();
    chk("post_rst_count", fifo_count, 0);
    chk("post_rst_req", write_req, 0);

    // Single-word timing table
    for (int v = 0; v < 4; v++) begin
      first_req = -1; req_n = 0; done_n = 0; done_c = -1; bad_hold = 0; first_addr = '0;
      write_gnt = vecs[v].gnt_idle;
      drive_word(vecs[v].addr, fill(vecs[v].pat));
      step();
      valid_dfx_data = 1'b0;
      chk("vec_count_c1", fifo_count, 1);
      for (int c = 1; c < 16; c++) begin
        if (c > 1) step();
        if (write_req) begin
          if (first_req < 0) begin
            first_req = c;
            first_addr = vrf_dst_addr;
          end
          req_n++;
          if (vrf_dst_addr !== vecs[v].addr || vrf_write_data !== fill(vecs[v].pat)) bad_hold = 1;
          write_gnt = (req_n > vecs[v].gdly);
        end else begin
          write_gnt = vecs[v].gnt_idle;
        end
        if (done_put_data) begin
          done_n++;
          done_c = c;
        end
      end
      chk("vec_first_req_cycle", first_req, 2);
      chk("vec_addr", first_addr, vecs[v].addr);
      chk("vec_req_len", req_n, vecs[v].req_len);
      chk("vec_done_pulses", done_n, 1);
      chk("vec_done_cycle", done_c, vecs[v].done_at);
      chk("vec_hold_stable", bad_hold, 0);
      chk("vec_count_end", fifo_count, 0);
    end
    write_gnt = 1'b0;

    // Burst of four, grant held high
    write_gnt = 1'b1;
    wbase = wr_addr_log.size(); dbase = done_cnt;
    for (int i = 1; i <= 4; i++) begin
      chk("burst_ready", dfx_ready, 1);
      drive_word(addr_t'(i), fill(8'(8'h10 * i)));
      step();
    end
    valid_dfx_data = 1'b0;
    repeat (20) step();
    chk("burst_writes", wr_addr_log.size() - wbase, 4);
    chk("burst_dones", done_cnt - dbase, 4);
    for (int i = 0; i < 4 && wbase + i < wr_addr_log.size(); i++) begin
      chk("burst_order", wr_addr_log[wbase+i], i + 1);
      chk_data("burst_data", wr_data_log[wbase+i], fill(8'(8'h10 * (i + 1))));
    end

    // Overflow: word 1 parks in the hold stage, 2..5 fill the FIFO, 6 is dropped
    write_gnt = 1'b0;
    wbase = wr_addr_log.size();
    drive_word(addr_t'(1), fill(8'h31));
    step();
    valid_dfx_data = 1'b0;
    repeat (2) step();
    chk("ovf_req_parked", write_req, 1);
    for (int i = 2; i <= 6; i++) begin
      if (i == 6) begin
        chk("ovf_full_count", fifo_count, 4);
        chk("ovf_ready_low", dfx_ready, 0);
        chk("ovf_not_yet", overflow, 0);
      end
      drive_word(addr_t'(i), fill(8'(8'h30 + i)));
      step();
    end
    valid_dfx_data = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_ready", dfx_ready, 0);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("ovf_clear", overflow, 0);
    drive_word(addr_t'(7), fill(8'h37));
    clear_overflow = 1'b1;
    step();
    valid_dfx_data = 1'b0;
    clear_overflow = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    chk("ovf_count_after_drop", fifo_count, 4);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("ovf_clear2", overflow, 0);
    write_gnt = 1'b1;
    repeat (25) step();
    chk("ovf_writes", wr_addr_log.size() - wbase, 5);
    for (int i = 0; i < 5 && wbase + i < wr_addr_log.size(); i++) begin
      chk("ovf_order", wr_addr_log[wbase+i], i + 1);
      chk_data("ovf_data", wr_data_log[wbase+i], fill(8'(8'h31 + i)));
    end
    chk("ovf_drained", fifo_count, 0);

    // Full FIFO with a pop and a push in the same cycle
    write_gnt = 1'b0;
    wbase = wr_addr_log.size();
    for (int i = 10; i <= 14; i++) begin
      drive_word(addr_t'(i), fill(8'(i)));
      step();
    end
    valid_dfx_data = 1'b0;
    chk("fp_full", fifo_count, 4);
    write_gnt = 1'b1;
    seen = 0;
    for (k = 0; k < 10 && !seen; k++) begin
      step();
      if (done_put_data) seen = 1;
    end
    chk("fp_done_seen", seen, 1);
    write_gnt = 1'b0;
    step();
    chk("fp_ready_low_at_pop", dfx_ready, 0);
    drive_word(addr_t'(15), fill(8'd15));
    step();
    valid_dfx_data = 1'b0;
    chk("fp_count_kept", fifo_count, 4);
    chk("fp_no_overflow", overflow, 0);
    write_gnt = 1'b1;
    repeat (25) step();
    chk("fp_writes", wr_addr_log.size() - wbase, 6);
    for (int i = 0; i < 6 && wbase + i < wr_addr_log.size(); i++) begin
      chk("fp_order", wr_addr_log[wbase+i], 10 + i);
      chk_data("fp_data", wr_data_log[wbase+i], fill(8'(10 + i)));
    end

    // Reset while a request is pending with two words queued
    write_gnt = 1'b0;
    for (int i = 20; i <= 22; i++) begin
      drive_word(addr_t'(i), fill(8'(i)));
      step();
    end
    valid_dfx_data = 1'b0;
    chk("mr_count", fifo_count, 2);
    chk("mr_req", write_req, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_rst_req", write_req, 0);
    chk("mr_rst_done", done_put_data, 0);
    chk("mr_rst_count", fifo_count, 0);
    chk("mr_rst_ready", dfx_ready, 1);
    chk("mr_rst_overflow", overflow, 0);
    chk("mr_rst_addr", vrf_dst_addr, 0);
    chk_data("mr_rst_data", vrf_write_data, '0);
    step();
    step();
    rst_n = 1'b1;
    wbase = wr_addr_log.size(); dbase = done_cnt;
    write_gnt = 1'b1;
    repeat (10) step();
    chk("mr_no_writes", wr_addr_log.size() - wbase, 0);
    chk("mr_no_dones", done_cnt - dbase, 0);
    chk("mr_count_after", fifo_count, 0);

    // Random traffic against an in-order reference queue
    wbase = wr_addr_log.size(); dbase = done_cnt;
    for (int c = 0; c < 400; c++) begin
      write_gnt = ($urandom_range(0, 99) < 50);
      if (dfx_ready && $urandom_range(0, 99) < 45) begin
        addr_t a;
        data_t d;
        a = addr_t'($urandom);
        d = rnd_data();
        exp_a.push_back(a);
        exp_d.push_back(d);
        drive_word(a, d);
      end else begin
        valid_dfx_data = 1'b0;
      end
      step();
    end
    valid_dfx_data = 1'b0;
    write_gnt = 1'b1;
    repeat (40) step();
    chk("rnd_write_count", wr_addr_log.size() - wbase, exp_a.size());
    chk("rnd_done_count", done_cnt - dbase, exp_a.size());
    for (int i = 0; i < exp_a.size() && wbase + i < wr_addr_log.size(); i++) begin
      chk("rnd_addr", wr_addr_log[wbase+i], exp_a[i]);
      chk_data("rnd_data", wr_data_log[wbase+i], exp_d[i]);
    end
    chk("rnd_overflow", overflow, 0);
    chk("rnd_count_end", fifo_count, 0);

    chk("done_follows_grant", bad_done, 0);
    chk("req_addr_data_stable", unstable, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
